keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl_if.sv | 11 +
 rtl/keypad_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Key-code handshake between the keypad scanner and its consumer.
// The scanner is the master: it presents key_code with key_valid and
// holds both until the consumer raises key_ready.
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row at a time, locks onto the first
// row showing a closed contact, debounces that press, reports one key code
// per press over a valid/ready handshake and waits for a debounced release
// before scanning resumes.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int DB_CYC     = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_en,
  input  logic [3:0]         col,
  output logic [3:0]         row,
  output logic               busy,
  keypad_scan_ctrl_if.master key_if
);

  typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, REPORT, RELEASE} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] DB_LAST     = 16'(DB_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  col_meta, col_s;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] db_q, db_d;
  logic [3:0]  pattern_q, pattern_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;

  // Lowest closed column wins when several keys share the driven row.
  function automatic logic [1:0] lowest_bit(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'b0000;
      col_s    <= 4'b0000;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      settle_q  <= 8'd0;
      db_q      <= 16'd0;
      pattern_q <= 4'b0000;
      code_q    <= 4'b0000;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      settle_q  <= settle_d;
      db_q      <= db_d;
      pattern_q <= pattern_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic: scan rows, debounce a locked press, hand off the
  // code, then debounce the release before moving to the next row.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    settle_d  = settle_q;
    db_d      = db_q;
    pattern_d = pattern_q;
    code_d    = code_q;
    valid_d   = valid_q;

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d   = SCAN;
          row_idx_d = 2'd0;
          settle_d  = 8'd0;
        end
      end
      SCAN: begin
        if (settle_q == SETTLE_LAST) begin
          if (col_s == 4'b0000) begin
            row_idx_d = row_idx_q + 2'd1;
            settle_d  = 8'd0;
            if (!scan_en) state_d = IDLE;
          end else begin
            pattern_d = col_s;
            col_idx_d = lowest_bit(col_s);
            db_d      = 16'd0;
            state_d   = DEBOUNCE;
          end
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      DEBOUNCE: begin
        if (col_s == pattern_q) begin
          if (db_q == DB_LAST) begin
            code_d  = {row_idx_q, col_idx_q};
            valid_d = 1'b1;
            state_d = REPORT;
          end else begin
            db_d = db_q + 16'd1;
          end
        end else begin
          row_idx_d = row_idx_q + 2'd1;
          settle_d  = 8'd0;
          state_d   = scan_en ? SCAN : IDLE;
        end
      end
      REPORT: begin
        if (valid_q && key_if.key_ready) begin
          valid_d = 1'b0;
          db_d    = 16'd0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (col_s == 4'b0000) begin
          if (db_q == DB_LAST) begin
            row_idx_d = row_idx_q + 2'd1;
            settle_d  = 8'd0;
            state_d   = scan_en ? SCAN : IDLE;
          end else begin
            db_d = db_q + 16'd1;
          end
        end else begin
          db_d = 16'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row drive and status decode; the locked row stays driven while busy.
  always_comb begin
    row  = (state_q == IDLE) ? 4'b0000 : (4'b0001 << row_idx_q);
    busy = (state_q == DEBOUNCE) || (state_q == REPORT) || (state_q == RELEASE);
  end

  assign key_if.key_valid = valid_q;
  assign key_if.key_code  = code_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a behavioural 4x4 keypad drives the
// column lines from the driven row, a consumer process drives key_ready and
// scores every transferred code against codes predicted from the keys pressed.
module tb_keypad_scan_ctrl;
  localparam int SETTLE = 4;
  localparam int DB     = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic [3:0] keys [4];

  keypad_scan_ctrl_if kif();

  keypad_scan_ctrl #(.SETTLE_CYC(SETTLE), .DB_CYC(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scan_en (scan_en),
    .col     (col),
    .row     (row),
    .busy    (busy),
    .key_if  (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key connects its row line to its column line.
  always_comb begin
    col = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (row[r]) col = col | keys[r];
  end

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int rise_count = 0;
  int cyc = 0;
  int busy_rise_cyc = 0;
  int ready_mode = 1;
  int exp_total = 0;
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_busy = 1'b0;
  logic [3:0] prev_code = 4'b0000;
  logic [3:0] exp_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Key code a press of 'mask' on row r must produce: row index, lowest column.
  function automatic logic [3:0] expect_code(input int r, input logic [3:0] mask);
    int low = 0;
    for (int c = 3; c >= 0; c--)
      if (mask[c]) low = c;
    return {2'(r), 2'(low)};
  endfunction

  // Consumer and monitor: drives key_ready, scores transfers, checks
  // hold-while-stalled, one pulse per press and debounce latency.
  initial begin
    kif.key_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall    = 1'b0;
        prev_valid    = 1'b0;
        prev_busy     = 1'b0;
        kif.key_ready = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", 32'(kif.key_valid), 32'd1);
          checkOutput("hold_code", 32'(kif.key_code), 32'(prev_code));
        end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (kif.key_valid && !prev_valid) begin
          rise_count++;
          checkOutput("db_latency", 32'(cyc - busy_rise_cyc), 32'(DB));
          checkOutput("busy_in_report", 32'(busy), 32'd1);
        end
        case (ready_mode)
          0:       kif.key_ready = 1'b0;
          1:       kif.key_ready = 1'b1;
          default: kif.key_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (kif.key_valid && kif.key_ready) begin
          hs_count++;
          if (exp_q.size() > 0) checkOutput("key_code", 32'(kif.key_code), 32'(exp_q.pop_front()));
          else                  checkOutput("spurious_key", 32'(kif.key_code), 32'hFFFF_FFFF);
        end
        prev_stall = kif.key_valid && !kif.key_ready;
        prev_code  = kif.key_code;
        prev_valid = kif.key_valid;
        prev_busy  = busy;
      end
    end
  end

  // One press of 'mask' on row r: expect one code, hold a while, release.
  task automatic applyStimulus(input int r, input logic [3:0] mask, input int hold);
    int base;
    exp_q.push_back(expect_code(r, mask));
    exp_total++;
    base = hs_count;
    keys[r] = mask;
    for (int i = 0; i < 300 && hs_count == base; i++) @(negedge clk);
    checkOutput("press_accepted", 32'(hs_count > base), 32'd1);
    repeat (hold) @(negedge clk);
    keys[r] = 4'b0000;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int   base;
    int   base_rise;
    int   abandons;
    logic seen;
    logic pb;
    rst_n   = 1'b0;
    scan_en = 1'b0;
    for (int r = 0; r < 4; r++) keys[r] = 4'b0000;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_row", 32'(row), 32'd0);
    checkOutput("reset_valid", 32'(kif.key_valid), 32'd0);
    checkOutput("reset_code", 32'(kif.key_code), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;

    // Parked in IDLE while scanning is disabled.
    repeat (4) @(negedge clk);
    checkOutput("idle_row", 32'(row), 32'd0);

    // Idle keypad: each row driven SETTLE cycles in turn, period 4*SETTLE.
    scan_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checkOutput("scan_row", 32'(row), 32'(4'b0001 << ((k / SETTLE) % 4)));
      checkOutput("scan_busy", 32'(busy), 32'd0);
      checkOutput("scan_valid", 32'(kif.key_valid), 32'd0);
    end

    // Key on row 2, column 2; release must be debounced before row 3.
    ready_mode = 1;
    exp_q.push_back(4'b1010);
    exp_total++;
    base = hs_count;
    keys[2] = 4'b0100;
    for (int i = 0; i < 300 && hs_count == base; i++) @(negedge clk);
    checkOutput("row2_accepted", 32'(hs_count > base), 32'd1);
    repeat (10) @(negedge clk);
    keys[2] = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("release_row", 32'(row), (i < 10) ? 32'h4 : 32'h8);
    end
    repeat (30) @(negedge clk);

    // Same press with the consumer stalled for 20 cycles.
    ready_mode = 0;
    exp_q.push_back(4'b1010);
    exp_total++;
    keys[2] = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid) seen = 1'b1;
    end
    checkOutput("stall_valid_seen", 32'(seen), 32'd1);
    repeat (20) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(kif.key_valid), 32'd1);
      checkOutput("stall_code", 32'(kif.key_code), 32'hA);
    end
    base = hs_count;
    ready_mode = 1;
    for (int i = 0; i < 50 && hs_count == base; i++) @(negedge clk);
    checkOutput("stall_transfer", 32'(hs_count - base), 32'd1);
    repeat (40) @(negedge clk);
    keys[2] = 4'b0000;
    repeat (30) @(negedge clk);

    // Bouncing contact on row 1: every debounce attempt is abandoned.
    base_rise = rise_count;
    abandons = 0;
    pb = busy;
    for (int i = 0; i < 96; i++) begin
      keys[1] = (((i / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (pb && !busy) begin
        abandons++;
        checkOutput("bounce_next_row", 32'(row), 32'h4);
      end
      pb = busy;
    end
    keys[1] = 4'b0000;
    repeat (20) @(negedge clk);
    checkOutput("bounce_no_key", 32'(rise_count), 32'(base_rise));
    checkOutput("bounce_seen", 32'(abandons > 0), 32'd1);
    applyStimulus(1, 4'b0001, 5);

    // Two keys on row 0: lowest column reported.
    applyStimulus(0, 4'b1010, 5);

    // Random presses with a randomly stalling consumer.
    ready_mode = 2;
    for (int n = 0; n < 8; n++)
      applyStimulus($urandom_range(0, 3), 4'($urandom_range(1, 15)), $urandom_range(0, 40));

    // scan_en dropped mid-press: handshake and release finish, then IDLE.
    ready_mode = 1;
    exp_q.push_back(expect_code(3, 4'b0110));
    exp_total++;
    base = hs_count;
    keys[3] = 4'b0110;
    for (int i = 0; i < 300 && !busy; i++) @(negedge clk);
    scan_en = 1'b0;
    for (int i = 0; i < 300 && hs_count == base; i++) @(negedge clk);
    checkOutput("drop_transfer", 32'(hs_count - base), 32'd1);
    repeat (5) @(negedge clk);
    keys[3] = 4'b0000;
    repeat (30) @(negedge clk);
    checkOutput("drop_idle_row", 32'(row), 32'd0);
    checkOutput("drop_idle_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("drop_stays_idle", 32'(row), 32'd0);
    scan_en = 1'b1;

    // Reset while a code is pending: dropped without a handshake.
    ready_mode = 0;
    keys[0] = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid) seen = 1'b1;
    end
    checkOutput("rst_valid_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(kif.key_valid), 32'd0);
    checkOutput("rst_mid_row", 32'(row), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    keys[0] = 4'b0000;
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_restart_row", 32'(row), 32'h1);
    repeat (40) @(negedge clk);

    // Every predicted code transferred once, one valid pulse per press
    // plus the one dropped by reset.
    checkOutput("handshakes", 32'(hs_count), 32'(exp_total));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("valid_pulses", 32'(rise_count), 32'(exp_total + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
